// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory block.
// Holds the load/run state encoding and width helpers.
package prog_mem_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Index width for an array of depth words; at least one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Program word storage: one write port, one synchronous read port.
// Contents are never reset; validity is tracked by the parent.
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256,
    parameter int IW     = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prog_mem.sv
// Loadable program memory: stream a program in, then serve fetches.
// Unwritten or out-of-range words always read back as zero.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_err,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data
);

    localparam int NW = 2**ADDR_W;
    localparam int IW = idx_w(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W:0]   wptr;
    logic [NW-1:0]     written;
    logic              err_q;
    logic              acc;
    logic              wr_en;
    logic              ovf;
    logic              fire;
    logic              in_rng;
    logic              hit;
    logic              hit_q;
    logic              fv_q;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] hold_q;

    // A restart wins over the current pointer, so a word arriving
    // with load_start lands at word 0.
    always_comb begin
        wptr        = load_start ? '0 : ptr;
        acc         = load_valid && (load_start || state == LOAD);
        wr_en       = acc && (wptr < DEPTH_C);
        ovf         = acc && !wr_en;
        load_ready  = (state == LOAD);
        fetch_ready = (state == RUN);
        fire        = fetch_req && fetch_ready;
        in_rng      = ({1'b0, fetch_addr} < DEPTH_C);
        hit         = in_rng && written[fetch_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            written <= '0;
            err_q   <= 1'b0;
            fv_q    <= 1'b0;
            hit_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            if (load_start) begin
                state   <= LOAD;
                ptr     <= '0;
                written <= '0;
                err_q   <= 1'b0;
            end
            if (wr_en) begin
                written[wptr[ADDR_W-1:0]] <= 1'b1;
                ptr <= wptr + (ADDR_W+1)'(1);
            end
            if (ovf) begin
                err_q <= 1'b1;
            end
            if (acc && load_last) begin
                state <= RUN;
            end
            fv_q <= fire;
            if (fire) begin
                hit_q <= hit;
            end
            if (fv_q) begin
                hold_q <= fetch_data;
            end
        end
    end

    prog_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr[IW-1:0]),
        .wdata (load_data),
        .re    (fire && in_rng),
        .raddr (fetch_addr[IW-1:0]),
        .rdata (rd_data)
    );

    assign load_err    = err_q;
    assign fetch_valid = fv_q;
    assign fetch_data  = fv_q ? (hit_q ? rd_data : '0) : hold_q;

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set address width.
REQ-002 Parameter DATA_W, default 8, SHALL set instruction word width.
REQ-003 Parameter DEPTH, default 2**ADDR_W, SHALL set implemented words; legal range 1..2**ADDR_W.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load_start  input  1  one-cycle pulse; starts program load at word 0.
REQ-007 load_valid  input  1  load_data carries a word this cycle.
REQ-008 load_data  input  DATA_W  program word to store.
REQ-009 load_last  input  1  qualifies final load word.
REQ-010 load_ready  output  1  memory accepts a load word this cycle.
REQ-011 load_err  output  1  sticky overflow flag.
REQ-012 fetch_req  input  1  fetch request.
REQ-013 fetch_addr  input  ADDR_W  fetch address.
REQ-014 fetch_ready  output  1  fetch accepted this cycle.
REQ-015 fetch_valid  output  1  fetch_data valid this cycle.
REQ-016 fetch_data  output  DATA_W  fetched word.

Function
REQ-017 The block SHALL implement FSM states IDLE, LOAD, RUN.
REQ-018 IDLE: load_start -> LOAD with write pointer 0; load_ready=0, fetch_ready=0.
REQ-019 LOAD: load_ready=1; load_valid&&load_ready SHALL write load_data at pointer, set that word's written bit, increment pointer.
REQ-020 LOAD: accepted word with load_last=1 SHALL transition to RUN next cycle.
REQ-021 LOAD: load_valid when pointer==DEPTH SHALL discard data, set load_err, stay in LOAD until load_last.
REQ-022 RUN: fetch_ready=1; load_ready=0; load_valid ignored.
REQ-023 RUN: accepted fetch SHALL yield fetch_valid=1 exactly one cycle later with the word; back-to-back fetches SHALL sustain one per cycle.
REQ-024 Fetch of fetch_addr>=DEPTH or of an unwritten word SHALL return all-zero data with fetch_valid=1.
REQ-025 fetch_valid SHALL be 0 in any cycle not following an accepted fetch.
REQ-026 load_start in LOAD or RUN SHALL restart: pointer 0, all written bits cleared, load_err cleared, state LOAD; in-flight fetch result of the previous cycle SHALL still be delivered.
REQ-027 load_start and load_valid in the same cycle SHALL restart first, then write load_data at word 0.
REQ-028 fetch_data SHALL hold its last value when fetch_valid=0.
REQ-029 Write pointer SHALL be ADDR_W+1 bits wide so DEPTH=2**ADDR_W is detectable without wrap.

Reset
REQ-030 rst_n low SHALL force state IDLE, pointer 0, all written bits 0, load_err 0, load_ready 0, fetch_ready 0, fetch_valid 0, fetch_data 0, regardless of clock.
REQ-031 Memory array contents SHALL NOT be reset; written bits alone SHALL guarantee zero reads.
REQ-032 Reset mid-LOAD SHALL discard the partial program; next run requires a new load_start.

Structure
REQ-033 State enum (IDLE, LOAD, RUN) SHALL live in shared package prog_mem_pkg with instruction-width default constant.
REQ-034 Storage SHALL be sub-module prog_mem_array (single write port, single synchronous read port, no reset).

Verification
REQ-035 Load 0x05,0x81,0x0A (last on third) then fetch addr 1 -> fetch_valid and 0x81 one cycle later; fetch_ready high from cycle after last.
REQ-036 Fetch addrs 0,1,2,7 back-to-back -> 0x05,0x81,0x0A,0x00 on four consecutive cycles.
REQ-037 DEPTH=4: load 6 words, last on sixth -> load_err=1, words 0..3 hold first four, RUN entered.
REQ-038 Fetch request in IDLE and LOAD -> fetch_ready=0, fetch_valid stays 0.
REQ-039 Assert rst_n low mid-load between clock edges -> outputs zero immediately; after release fetch_ready=0 until new load completes.
REQ-040 In RUN, load_start with load_valid 0xC1 -> LOAD, word 0=0xC1, previously loaded word 1 reads 0x00 after reload ends.
